// File: rtl/sort_rank_select_pkg.sv
// sort_stage_pkg: FSM state encoding, count width and median rank helpers for sort_rank_select
package sort_stage_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction
  function automatic int med_lo(input int size);
    return size / 2 - 1;
  endfunction
  function automatic int med_hi(input int size);
    return size / 2;
  endfunction
endpackage

// File: rtl/sort_rank_select_tap.sv
// sort_rank_tap: captures d when rank matches target; clr zeroes it at frame start (ports: clk, rst, clr, en, rank, target, d, q)
module sort_rank_tap #(
  parameter int CW = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CW-1:0]    rank,
  input  logic [CW-1:0]    target,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en && rank == target) q <= d;
    else if (clr) q <= '0;
endmodule

// File: rtl/sort_rank_select.sv
// sort_rank_select: min/max/median/percentile of one sorted frame, with length and optional order check (SORT_RANK_ORDER_CHECK_EN); ports clk, rst, d, active, pct_index -> min_q, max_q, median_q, pct_q, result_valid, len_err, order_err
module sort_rank_select
  import sort_stage_pkg::*;
#(
  parameter int SIZE = 1024,
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        d,
  input  logic                    active,
  input  logic [$clog2(SIZE)-1:0] pct_index,
  output logic [WIDTH-1:0]        min_q,
  output logic [WIDTH-1:0]        max_q,
  output logic [WIDTH-1:0]        median_q,
  output logic [WIDTH-1:0]        pct_q,
  output logic                    result_valid,
  output logic                    len_err,
  output logic                    order_err
);
  localparam int CW = cnt_w(SIZE);
  localparam int PW = $clog2(SIZE);
  state_t state, state_n;
  logic [CW-1:0] count, rank, pct_tgt;
  logic [PW-1:0] pct_lat;
  logic [WIDTH-1:0] last, min_t, lo_t, hi_t, pct_t;
  logic [WIDTH:0] med_sum;
  logic long_f, ord_f, start, acc, fin;
  // a frame may start from IDLE or directly out of DONE (one-cycle gap)
  always_comb begin
    start = active && state != COLLECT;
    acc = start || (state == COLLECT && active && count < CW'(SIZE));
    fin = state == COLLECT && !active;
    rank = start ? '0 : count;
    pct_tgt = start ? CW'(pct_index) : CW'(pct_lat);
    med_sum = {1'b0, lo_t} + {1'b0, hi_t};
    state_n = start ? COLLECT : fin ? DONE : state == DONE ? IDLE : state;
  end
  sort_rank_tap #(.CW(CW), .WIDTH(WIDTH)) u_min (.clk(clk), .rst(rst), .clr(start), .en(acc),
    .rank(rank), .target('0), .d(d), .q(min_t));
  sort_rank_tap #(.CW(CW), .WIDTH(WIDTH)) u_lo (.clk(clk), .rst(rst), .clr(start), .en(acc),
    .rank(rank), .target(CW'(med_lo(SIZE))), .d(d), .q(lo_t));
  sort_rank_tap #(.CW(CW), .WIDTH(WIDTH)) u_hi (.clk(clk), .rst(rst), .clr(start), .en(acc),
    .rank(rank), .target(CW'(med_hi(SIZE))), .d(d), .q(hi_t));
  sort_rank_tap #(.CW(CW), .WIDTH(WIDTH)) u_pct (.clk(clk), .rst(rst), .clr(start), .en(acc),
    .rank(rank), .target(pct_tgt), .d(d), .q(pct_t));
`ifdef SORT_RANK_ORDER_CHECK_EN
  // last already holds the previous accepted sample
  always_ff @(posedge clk)
    if (rst || start) ord_f <= 1'b0;
    else if (acc && d < last) ord_f <= 1'b1;
`else
  assign ord_f = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      pct_lat <= '0;
      last <= '0;
      long_f <= 1'b0;
      min_q <= '0;
      max_q <= '0;
      median_q <= '0;
      pct_q <= '0;
      result_valid <= 1'b0;
      len_err <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (start) begin
        count <= CW'(1);
        pct_lat <= pct_index;
        long_f <= 1'b0;
      end else if (acc) count <= count + 1'b1;
      else if (state == COLLECT && active) long_f <= 1'b1;
      if (acc) last <= d;
      result_valid <= fin;
      if (fin) begin
        min_q <= min_t;
        max_q <= last;
        median_q <= med_sum[WIDTH:1];
        pct_q <= pct_t;
        len_err <= long_f || count != CW'(SIZE);
        order_err <= ord_f;
      end
    end
endmodule

// File: tb/tb_sort_rank_select.sv
// tb_sort_rank_select: scoreboard bench for sort_rank_select at SIZE=8, WIDTH=12
module tb_sort_rank_select;
  localparam int SIZE = 8;
  localparam int WIDTH = 12;
  typedef struct {
    int unsigned mn, mx, md, pc, cy;
    bit le, oe;
  } exp_t;
  logic clk = 0, rst = 1, active = 0, result_valid, len_err, order_err;
  logic [WIDTH-1:0] d = '0, min_q, max_q, median_q, pct_q;
  logic [2:0] pct_index = '0;
  int unsigned cyc = 0, checks = 0, failures = 0, npulse = 0, nframes = 0;
  exp_t sb[$];
  sort_rank_select #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .d(d), .active(active),
    .pct_index(pct_index), .min_q(min_q), .max_q(max_q), .median_q(median_q), .pct_q(pct_q),
    .result_valid(result_valid), .len_err(len_err), .order_err(order_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && result_valid) begin
      exp_t e;
      npulse++;
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cy);
        chk("min", min_q, e.mn);
        chk("max", max_q, e.mx);
        chk("median", median_q, e.md);
        chk("pct", pct_q, e.pc);
        chk("len_err", len_err, e.le);
        chk("order_err", order_err, e.oe);
      end
    end
  // drives one frame then one idle cycle; model pushes the expected result
  task automatic send(input int unsigned s[$], input int p, input bit expect_result);
    exp_t e;
    int n, a;
    n = s.size();
    a = n < SIZE ? n : SIZE;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      active = 1;
      d = WIDTH'(s[i]);
      pct_index = i == 0 ? 3'(p) : 3'(~p);
    end
    e.mn = s[0];
    e.mx = s[a-1];
    e.md = ((a > SIZE/2-1 ? s[SIZE/2-1] : 0) + (a > SIZE/2 ? s[SIZE/2] : 0)) / 2;
    e.pc = a > p ? s[p] : 0;
    e.le = n != SIZE;
    e.oe = 0;
`ifdef SORT_RANK_ORDER_CHECK_EN
    for (int i = 1; i < a; i++) if (s[i] < s[i-1]) e.oe = 1;
`endif
    e.cy = cyc + 2;
    if (expect_result) begin
      sb.push_back(e);
      nframes++;
    end
    @(posedge clk); #1;
    active = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int unsigned q[$];
    idle(3);
    chk("rst_min", min_q, 0);
    chk("rst_max", max_q, 0);
    chk("rst_median", median_q, 0);
    chk("rst_pct", pct_q, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_len", len_err, 0);
    chk("rst_order", order_err, 0);
    rst = 0;
    idle(2);
    q = {3, 5, 7, 9, 11, 13, 15, 17};
    send(q, 6, 1); idle(3);
    q = {0, 0, 4, 4, 5, 4095, 4095, 4095};
    send(q, 0, 1); idle(3);
    q = {1, 2, 3};
    send(q, 6, 1); idle(3);
    q = {10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
    send(q, 7, 1); idle(3);
    q = {10, 11, 12, 13, 14, 15, 16, 17};
    send(q, 4, 1);
    q = {20, 21, 22, 23, 24, 25, 26, 27};
    send(q, 3, 1); idle(3);
    q = {100, 200, 300, 400};
    send(q, 2, 0);
    rst = 1;
    idle(1);
    rst = 0;
    q = {30, 31, 32, 33, 34, 35, 36, 37};
    send(q, 7, 1); idle(3);
    q = {1, 2, 3, 2, 4, 5, 6, 7};
    send(q, 3, 1); idle(3);
    q = {2, 4, 6, 8, 10, 12, 14, 16};
    send(q, 1, 1); idle(3);
    q = {};
    for (int i = 0; i < SIZE; i++) q.push_back($urandom_range(0, 4095));
    q.sort();
    send(q, 5, 1);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    idle(3);
    chk("drain", sb.size(), 0);
    chk("pulses", npulse, nframes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
